mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word-addressed memory target with optional wait states.
// Tracks completed transfers, instruction fetches and sticky out-of-range accesses.
module mem_responder #(
  parameter int WORDS       = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err_oob,
  output logic [15:0] txn_count,
  output logic [15:0] fetch_count
);

  localparam int         AW        = $clog2(WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [3:0]      cnt_r;
  logic [3:0]      cnt_s;
  logic [AW-1:0]   idx_r;
  logic            oob_r;
  logic [3:0]      wstrb_r;
  logic [31:0]     wdata_r;
  logic            instr_r;
  logic            ready_r;
  logic [31:0]     rdata_r;
  logic            err_r;
  logic [15:0]     txn_r;
  logic [15:0]     fetch_r;
  logic [31:0]     mem_r [WORDS];

  logic [AW-1:0]   req_idx_s;
  logic            req_oob_s;
  logic [AW-1:0]   rd_idx_s;
  logic            rd_oob_s;
  logic            complete_s;
  logic            unused_s;

  assign req_idx_s  = mem_addr[AW+1:2];
  assign req_oob_s  = |mem_addr[31:AW+2];
  assign complete_s = (state_r == ST_RESP) && mem_valid;
  assign unused_s   = ^mem_addr[1:0];

  // Next-state and wait-counter logic; dropping mem_valid aborts the request.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_valid) begin
          cnt_s   = WAIT_INIT;
          state_s = HAS_WAIT ? ST_WAIT : ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!mem_valid) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          state_s = ST_RESP;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Word about to be presented: live address when responding straight from IDLE.
  always_comb begin
    if (state_r == ST_IDLE) begin
      rd_idx_s = req_idx_s;
      rd_oob_s = req_oob_s;
    end else begin
      rd_idx_s = idx_r;
      rd_oob_s = oob_r;
    end
  end

  // Control state, request capture, registered response and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      oob_r   <= 1'b0;
      wstrb_r <= 4'd0;
      wdata_r <= 32'd0;
      instr_r <= 1'b0;
      ready_r <= 1'b0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
      txn_r   <= 16'd0;
      fetch_r <= 16'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (state_r == ST_IDLE && mem_valid) begin
        idx_r   <= req_idx_s;
        oob_r   <= req_oob_s;
        wstrb_r <= mem_wstrb;
        wdata_r <= mem_wdata;
        instr_r <= mem_instr;
      end
      ready_r <= (state_s == ST_RESP);
      // Read data is the pre-write word since stores only land at completion.
      rdata_r <= (state_s == ST_RESP && !rd_oob_s) ? mem_r[rd_idx_s] : 32'd0;
      if (complete_s) begin
        txn_r <= txn_r + 16'd1;
        if (instr_r) begin
          fetch_r <= fetch_r + 16'd1;
        end
        if (oob_r) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  // Backing store: byte-masked write on completion; contents are never reset.
  always_ff @(posedge clk) begin
    if (!reset && complete_s && !oob_r) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_r[b]) begin
          mem_r[idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  assign mem_ready   = ready_r;
  assign mem_rdata   = rdata_r;
  assign err_oob     = err_r;
  assign txn_count   = txn_r;
  assign fetch_count = fetch_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with 0, 3 and 4 wait states
// share the request bus; each has its own mem_valid.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        instr;
  logic        v0, v3, v4;
  logic        rdy0, rdy3, rdy4;
  logic [31:0] rd0, rd3, rd4;
  logic        err0, err3, err4;
  logic [15:0] txn0, txn3, txn4;
  logic [15:0] fet0, fet3, fet4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.WORDS(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_valid(v0), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy0), .mem_rdata(rd0),
    .err_oob(err0), .txn_count(txn0), .fetch_count(fet0));

  mem_responder #(.WORDS(32), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .mem_valid(v3), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy3), .mem_rdata(rd3),
    .err_oob(err3), .txn_count(txn3), .fetch_count(fet3));

  mem_responder #(.WORDS(32), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .mem_valid(v4), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy4), .mem_rdata(rd4),
    .err_oob(err4), .txn_count(txn4), .fetch_count(fet4));

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; v0 = 1'b0; v3 = 1'b0; v4 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete transfer on the selected instance; lat = cycles to ready, -1 on timeout.
  task automatic xfer(input int sel, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic ins,
                      output logic [31:0] rd, output int lat);
    logic r;
    addr = a; wdata = wd; wstrb = ws; instr = ins;
    case (sel)
      0: v0 = 1'b1;
      3: v3 = 1'b1;
      default: v4 = 1'b1;
    endcase
    lat = -1;
    rd  = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      case (sel)
        0: r = rdy0;
        3: r = rdy3;
        default: r = rdy4;
      endcase
      if (r) begin
        lat = k;
        case (sel)
          0: rd = rd0;
          3: rd = rd3;
          default: rd = rd4;
        endcase
        break;
      end
    end
    @(negedge clk);
    v0 = 1'b0; v3 = 1'b0; v4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; v0 = 1'b1; v3 = 1'b1; v4 = 1'b1;
    addr = 32'h4; wdata = 32'h0; wstrb = 4'h0; instr = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", rdy0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rd0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err0); end
    checks++; if (txn0 !== 16'h0) begin errors++; $display("FAIL reset_txn got %h exp 0", txn0); end
    checks++; if (fet0 !== 16'h0) begin errors++; $display("FAIL reset_fetch got %h exp 0", fet0); end
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL reset_ready4 got %b exp 0", rdy4); end
    reset = 1'b0; v3 = 1'b0; v4 = 1'b0;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL first_accept got %b exp 1", rdy0); end
    @(negedge clk);
    v0 = 1'b0;
    checks++; if (txn0 !== 16'd1) begin errors++; $display("FAIL first_txn got %0d exp 1", txn0); end
    checks++; if (fet0 !== 16'd1) begin errors++; $display("FAIL first_fetch got %0d exp 1", fet0); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int lat;
    do_reset();
    xfer(0, 32'h04, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency got %0d exp 1", lat); end
    xfer(0, 32'h04, 32'h0, 4'h0, 1'b0, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rd_latency got %0d exp 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    checks++; if (txn0 !== 16'd2) begin errors++; $display("FAIL wr_rd_txn got %0d exp 2", txn0); end
    checks++; if (fet0 !== 16'd0) begin errors++; $display("FAIL wr_rd_fetch got %0d exp 0", fet0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL idle_rdata got %h exp 0", rd0); end
  endtask

  task automatic test_byte_strobes();
    logic [31:0] rd;
    int lat;
    xfer(0, 32'h08, 32'h11223344, 4'hF, 1'b0, rd, lat);
    xfer(0, 32'h08, 32'hAABBCCDD, 4'h5, 1'b0, rd, lat);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL strobe_prewrite got %h exp 11223344", rd); end
    xfer(0, 32'h08, 32'h0, 4'h0, 1'b0, rd, lat);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge got %h exp 11bb33dd", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic [31:0] exp_d;
    logic exp_r;
    int lat;
    do_reset();
    xfer(3, 32'h0C, 32'hCAFEF00D, 4'hF, 1'b0, rd, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wait3_wr_latency got %0d exp 4", lat); end
    addr = 32'h0C; wstrb = 4'h0; v3 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_r = (k == 4);
      exp_d = (k == 4) ? 32'hCAFEF00D : 32'h0;
      checks++; if (rdy3 !== exp_r) begin errors++; $display("FAIL wait3_ready cyc %0d got %b exp %b", k, rdy3, exp_r); end
      checks++; if (rd3 !== exp_d) begin errors++; $display("FAIL wait3_rdata cyc %0d got %h exp %h", k, rd3, exp_d); end
    end
    @(negedge clk);
    v3 = 1'b0;
    checks++; if (txn3 !== 16'd2) begin errors++; $display("FAIL wait3_txn got %0d exp 2", txn3); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int lat;
    do_reset();
    xfer(0, 32'h00, 32'h01234567, 4'hF, 1'b0, rd, lat);
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL oob_clear got %b exp 0", err0); end
    xfer(0, 32'h80, 32'hFFFFFFFF, 4'hF, 1'b0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oob_wr_rdata got %h exp 0", rd); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL oob_set got %b exp 1", err0); end
    xfer(0, 32'h80, 32'h0, 4'h0, 1'b0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oob_rd_rdata got %h exp 0", rd); end
    xfer(0, 32'h80000000, 32'h0, 4'h0, 1'b0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oob_high_rdata got %h exp 0", rd); end
    xfer(0, 32'h00, 32'h0, 4'h0, 1'b0, rd, lat);
    checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL oob_word0 got %h exp 01234567", rd); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL oob_sticky got %b exp 1", err0); end
    do_reset();
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL oob_reset got %b exp 0", err0); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last;
    do_reset();
    addr = 32'h04; wstrb = 4'h0; instr = 1'b1; v0 = 1'b1;
    pulses = 0;
    last = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rdy0) begin
        checks++; if (c - last !== 2 && pulses > 0) begin errors++; $display("FAIL b2b_gap got %0d exp 2", c - last); end
        checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata got %h exp deadbeef", rd0); end
        last = c;
        pulses++;
        if (pulses == 3) break;
      end
    end
    @(negedge clk);
    v0 = 1'b0;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
    checks++; if (last !== 5) begin errors++; $display("FAIL b2b_last_cycle got %0d exp 5", last); end
    checks++; if (txn0 !== 16'd3) begin errors++; $display("FAIL b2b_txn got %0d exp 3", txn0); end
    checks++; if (fet0 !== 16'd3) begin errors++; $display("FAIL b2b_fetch got %0d exp 3", fet0); end
    instr = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic seen;
    int lat;
    do_reset();
    xfer(4, 32'h14, 32'h55555555, 4'hF, 1'b0, rd, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL wait4_latency got %0d exp 5", lat); end
    addr = 32'h14; wdata = 32'hAAAAAAAA; wstrb = 4'hF; v4 = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= rdy4; end
    v4 = 1'b0;
    repeat (6) begin @(negedge clk); seen |= rdy4; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", seen); end
    checks++; if (txn4 !== 16'd1) begin errors++; $display("FAIL abort_txn got %0d exp 1", txn4); end
    v4 = 1'b1;
    repeat (3) begin @(negedge clk); seen |= rdy4; end
    reset = 1'b1;
    @(negedge clk);
    seen |= rdy4;
    reset = 1'b0; v4 = 1'b0;
    repeat (6) begin @(negedge clk); seen |= rdy4; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_abort_ready got %b exp 0", seen); end
    checks++; if (txn4 !== 16'd0) begin errors++; $display("FAIL reset_abort_txn got %0d exp 0", txn4); end
    xfer(4, 32'h14, 32'h0, 4'h0, 1'b0, rd, lat);
    checks++; if (rd !== 32'h55555555) begin errors++; $display("FAIL abort_nowrite got %h exp 55555555", rd); end
    checks++; if (txn4 !== 16'd1) begin errors++; $display("FAIL abort_final_txn got %0d exp 1", txn4); end
  endtask

  initial begin
    reset = 1'b1;
    v0 = 1'b0; v3 = 1'b0; v4 = 1'b0;
    addr = 32'h0; wdata = 32'h0; wstrb = 4'h0; instr = 1'b0;
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_wait_states();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
